// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand-forwarding and hazard-detection unit for an in-order pipeline.
// It tracks the destination register of every in-flight instruction after ID
// in a small shift-register scoreboard. Stage 1 is EX and stage DEPTH is WB.
// From this it selects a forwarding source for each ID operand. It also
// detects load-use hazards (stall) and passes branch redirects through as
// pipeline flushes.
//
// Parameters
//   NREG      architectural register count (index width RW = clog2(NREG))
//   DEPTH     number of tracked stages after ID (2..8)
//   LOAD_STG  first stage whose load result can be forwarded (2..DEPTH)
//   CW        width of the saturating performance counters
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   id_valid            ID holds a real instruction
//   id_rs1, id_rs2      ID source register indices
//   id_use1, id_use2    ID instruction actually reads rs1 / rs2
//   id_rd               ID destination register index
//   id_regwrite         ID instruction writes id_rd
//   id_is_load          ID instruction is a load
//   ex_redirect         EX resolved a taken branch/jump this cycle
//   stall               hold PC and IF/ID, insert bubble into EX
//   flush_ifid          squash IF/ID
//   flush_idex          squash ID/EX
//   fwd1_sel, fwd2_sel  0 = register file, k = result of stage k
//   stall_cnt           saturating count of stall cycles
//   flush_cnt           saturating count of redirect cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter  int NREG     = 32,
  parameter  int DEPTH    = 3,
  parameter  int LOAD_STG = 2,
  parameter  int CW       = 32,
  localparam int RW       = $clog2(NREG),
  localparam int SW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_is_load,
  input  logic          ex_redirect,
  output logic          stall,
  output logic          flush_ifid,
  output logic          flush_idex,
  output logic [SW-1:0] fwd1_sel,
  output logic [SW-1:0] fwd2_sel,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  // Scoreboard entry k mirrors the instruction currently in stage k.
  logic [DEPTH:1] sb_v;
  logic [DEPTH:1] sb_wr;
  logic [DEPTH:1] sb_ld;
  logic [RW-1:0]  sb_rd [1:DEPTH];

  logic          hit1, hit2;
  logic          ld1, ld2;
  logic [SW-1:0] stg1, stg2;
  logic          fwdable1, fwdable2;
  logic          hazard1, hazard2;
  logic          load_use;
  logic          load_id;

  // Find the governing producer for each source. The loop runs from the
  // oldest stage toward the youngest, so the last match written (smallest k)
  // is the youngest one and wins. Register x0 is never a producer.
  always_comb begin
    hit1 = 1'b0;
    ld1  = 1'b0;
    stg1 = '0;
    hit2 = 1'b0;
    ld2  = 1'b0;
    stg2 = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (sb_v[k] && sb_wr[k] && (sb_rd[k] == id_rs1) && (id_rs1 != '0)) begin
        hit1 = 1'b1;
        ld1  = sb_ld[k];
        stg1 = SW'(k);
      end
      if (sb_v[k] && sb_wr[k] && (sb_rd[k] == id_rs2) && (id_rs2 != '0)) begin
        hit2 = 1'b1;
        ld2  = sb_ld[k];
        stg2 = SW'(k);
      end
    end
  end

  // A load result becomes usable only from LOAD_STG onward. A younger
  // matching load therefore blocks the operand even when an older stage
  // holds a usable value, because the younger value is the correct one.
  // Every output is forced to zero while reset is held, independent of clk.
  always_comb begin
    fwdable1   = !ld1 || (int'(stg1) >= LOAD_STG);
    fwdable2   = !ld2 || (int'(stg2) >= LOAD_STG);
    hazard1    = id_use1 && hit1 && !fwdable1;
    hazard2    = id_use2 && hit2 && !fwdable2;
    load_use   = id_valid && (hazard1 || hazard2);
    stall      = reset && load_use && !ex_redirect;
    flush_ifid = reset && ex_redirect;
    flush_idex = reset && ex_redirect;
    fwd1_sel   = (reset && id_use1 && hit1 && fwdable1) ? stg1 : '0;
    fwd2_sel   = (reset && id_use2 && hit2 && fwdable2) ? stg2 : '0;
    load_id    = id_valid && !stall && !ex_redirect;
  end

  // Advance the scoreboard one stage per clock. The ID instruction enters
  // stage 1 only if it is actually issued; otherwise a bubble enters. The
  // event counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_v      <= '0;
      sb_wr     <= '0;
      sb_ld     <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        sb_rd[k] <= '0;
      end
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb_v[k]  <= sb_v[k-1];
        sb_wr[k] <= sb_wr[k-1];
        sb_ld[k] <= sb_ld[k-1];
        sb_rd[k] <= sb_rd[k-1];
      end
      sb_v[1]  <= load_id;
      sb_wr[1] <= id_regwrite;
      sb_ld[1] <= id_is_load;
      sb_rd[1] <= id_rd;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
      if (ex_redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Directed bench for fwd_hazard_unit. Two instances share the same inputs:
// one uses the default parameters, and one uses CW=4 so that the stall
// counter's saturation can be observed. Inputs change 1 time unit after the
// rising edge. Outputs are sampled on the falling edge, or a few units after
// an asynchronous reset change.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use1;
  logic       id_use2;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       ex_redirect;

  logic        stall;
  logic        flush_ifid;
  logic        flush_idex;
  logic [1:0]  fwd1_sel;
  logic [1:0]  fwd2_sel;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic        c4_stall;
  logic        c4_flush_ifid;
  logic        c4_flush_idex;
  logic [1:0]  c4_fwd1_sel;
  logic [1:0]  c4_fwd2_sel;
  logic [3:0]  c4_stall_cnt;
  logic [3:0]  c4_flush_cnt;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .stall       (stall),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .fwd1_sel    (fwd1_sel),
    .fwd2_sel    (fwd2_sel),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  fwd_hazard_unit #(.CW(4)) dut_c4 (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .stall       (c4_stall),
    .flush_ifid  (c4_flush_ifid),
    .flush_idex  (c4_flush_idex),
    .fwd1_sel    (c4_fwd1_sel),
    .fwd2_sel    (c4_fwd2_sel),
    .stall_cnt   (c4_stall_cnt),
    .flush_cnt   (c4_flush_cnt)
  );

  // 10-unit clock period; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one ID-stage instruction plus the redirect input.
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic wr, input logic ld, input logic redir);
    id_valid    = v;
    id_rs1      = rs1;
    id_use1     = u1;
    id_rs2      = rs2;
    id_use2     = u2;
    id_rd       = rd;
    id_regwrite = wr;
    id_is_load  = ld;
    ex_redirect = redir;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Move to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence. The scoreboard contents noted at each step are
  // {stage1, stage2, stage3}. Expected values were worked out by hand.
  initial begin
    reset = 1'b0;
    applyStimulus(1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 0, 1);
    #2;
    checkOutput("rst_stall", 32'(stall), 0);
    checkOutput("rst_flush_ifid", 32'(flush_ifid), 0);
    checkOutput("rst_flush_idex", 32'(flush_idex), 0);
    checkOutput("rst_fwd1", 32'(fwd1_sel), 0);
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    checkOutput("rst_flush_cnt", flush_cnt, 0);
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ADD x5 followed by an ADD that reads x5 (and x0 on the other port).
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
    @(negedge clk);
    checkOutput("add_first_stall", 32'(stall), 0);
    checkOutput("add_first_fwd1", 32'(fwd1_sel), 0);
    tick();
    applyStimulus(1, 5'd5, 1, 5'd0, 1, 5'd8, 1, 0, 0);
    @(negedge clk);
    checkOutput("add_use_fwd1", 32'(fwd1_sel), 1);
    checkOutput("add_use_fwd2_x0", 32'(fwd2_sel), 0);
    checkOutput("add_use_stall", 32'(stall), 0);
    checkOutput("no_redirect_flush", 32'(flush_ifid), 0);
    tick();

    // LW x6 then ADD x7,x6,x6 back to back: one stall cycle, then forward from stage 2.
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 0);
    @(negedge clk);
    checkOutput("lw_issue_stall", 32'(stall), 0);
    tick();
    applyStimulus(1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0, 0);
    @(negedge clk);
    checkOutput("loaduse_stall", 32'(stall), 1);
    checkOutput("loaduse_fwd1", 32'(fwd1_sel), 0);
    checkOutput("loaduse_cnt_before", stall_cnt, 0);
    tick();
    @(negedge clk);
    checkOutput("loaduse_stall_done", 32'(stall), 0);
    checkOutput("loaduse_fwd1_stg2", 32'(fwd1_sel), 2);
    checkOutput("loaduse_fwd2_stg2", 32'(fwd2_sel), 2);
    checkOutput("loaduse_stall_cnt", stall_cnt, 1);
    tick();

    // x5 written in stages 1 and 3: the youngest producer wins.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd5, 1, 5'd9, 1, 5'd10, 0, 0, 0);
    @(negedge clk);
    checkOutput("youngest_fwd1", 32'(fwd1_sel), 1);
    checkOutput("mid_fwd2", 32'(fwd2_sel), 2);
    tick();

    // Stage 1 writes x0 and stage 3 writes x5: the read of x5 comes from stage 3.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd5, 1, 5'd0, 1, 5'd12, 0, 0, 0);
    @(negedge clk);
    checkOutput("x0_young_fwd1_stg3", 32'(fwd1_sel), 3);
    checkOutput("x0_read_fwd2", 32'(fwd2_sel), 0);
    checkOutput("x0_young_stall", 32'(stall), 0);
    tick();

    // LW x0 followed by a read of x0 and x5 (no x5 producer left): no stall, no forwarding.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);
    tick();
    applyStimulus(1, 5'd5, 1, 5'd0, 1, 5'd13, 0, 0, 0);
    @(negedge clk);
    checkOutput("x0_load_stall", 32'(stall), 0);
    checkOutput("no_x5_fwd1", 32'(fwd1_sel), 0);
    checkOutput("x0_load_fwd2", 32'(fwd2_sel), 0);
    tick();

    // A load-use hazard and a redirect in the same cycle: the redirect wins.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0);
    tick();
    applyStimulus(1, 5'd6, 1, 5'd0, 0, 5'd7, 1, 0, 1);
    @(negedge clk);
    checkOutput("redir_stall", 32'(stall), 0);
    checkOutput("redir_flush_ifid", 32'(flush_ifid), 1);
    checkOutput("redir_flush_idex", 32'(flush_idex), 1);
    tick();
    applyStimulus(1, 5'd6, 1, 5'd0, 0, 5'd7, 0, 0, 0);
    @(negedge clk);
    checkOutput("redir_bubble_stall", 32'(stall), 0);
    checkOutput("redir_bubble_fwd1", 32'(fwd1_sel), 2);
    checkOutput("redir_flush_cnt", flush_cnt, 1);
    checkOutput("redir_flush_clear", 32'(flush_idex), 0);
    checkOutput("redir_stall_cnt", stall_cnt, 1);
    tick();

    // Drain the pipeline, then repeat "LW x6 reading x6" to stall every odd cycle.
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();
    tick();
    tick();
    applyStimulus(1, 5'd6, 1, 5'd0, 0, 5'd6, 1, 1, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rep_stall_%0d", i), 32'(stall), 32'((i % 2) == 1));
      tick();
    end
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rep_stall_cnt", stall_cnt, 21);
    checkOutput("c4_stall_cnt_sat", 32'(c4_stall_cnt), 15);
    checkOutput("c4_flush_cnt", 32'(c4_flush_cnt), 1);
    tick();

    // Fill three valid entries, then assert reset mid-cycle.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd13, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd14, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd12, 1, 5'd13, 1, 5'd15, 1, 0, 1);
    @(negedge clk);
    checkOutput("pre_rst_fwd1", 32'(fwd1_sel), 3);
    checkOutput("pre_rst_fwd2", 32'(fwd2_sel), 2);
    checkOutput("pre_rst_flush", 32'(flush_ifid), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_fwd1", 32'(fwd1_sel), 0);
    checkOutput("mid_rst_fwd2", 32'(fwd2_sel), 0);
    checkOutput("mid_rst_flush_ifid", 32'(flush_ifid), 0);
    checkOutput("mid_rst_flush_idex", 32'(flush_idex), 0);
    checkOutput("mid_rst_stall", 32'(stall), 0);
    checkOutput("mid_rst_stall_cnt", stall_cnt, 0);
    checkOutput("mid_rst_flush_cnt", flush_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 5'd12, 1, 5'd0, 0, 5'd15, 1, 0, 0);
    #1;
    checkOutput("post_rst_fwd1", 32'(fwd1_sel), 0);
    checkOutput("post_rst_stall", 32'(stall), 0);
    tick();
    applyStimulus(1, 5'd15, 1, 5'd0, 0, 5'd16, 0, 0, 0);
    @(negedge clk);
    checkOutput("post_rst_first_entry", 32'(fwd1_sel), 1);
    checkOutput("post_rst_stall_cnt", stall_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
